opb_register_ppc2simulink_sync: RTL and testbench

//  Processor-to-fabric software register: OPB slave that accepts PPC writes into a
//  32-bit control word and drives it onto user_data_out for Simulink/user logic.

---
 rtl/opb_register_ppc2simulink_sync.sv | 74 +++++++
 tb/tb_opb_register_ppc2simulink_sync.sv | 131 +++++++++++++
 2 files changed

// File: rtl/opb_register_ppc2simulink_sync.sv
// opb_register_ppc2simulink_sync: OPB slave register driving a PPC-written 32-bit control word (0x0) plus a write counter (0x4) to user logic.
module opb_register_ppc2simulink_sync #(
  parameter logic [31:0] C_BASEADDR   = 32'h010C0400,
  parameter logic [31:0] C_HIGHADDR   = 32'h010C04FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_DEFAULT    = 32'h00000000,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [31:0]             user_data_out,
  output logic                    user_data_strobe
);
  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
  state_t state, state_n;
  logic hit, ack, sel_q, rnw_q, unused_ok;
  logic [0:3] be_q;
  logic [31:0] dbus_q, data, data_n, wr_count;
  assign hit = OPB_select && OPB_ABus >= C_BASEADDR && OPB_ABus <= C_HIGHADDR;
  assign ack = state == ACK;
  assign Sl_xferAck = ack;
  assign Sl_DBus = (ack && rnw_q) ? (sel_q ? wr_count : data) : '0;
  assign Sl_errAck = 1'b0;
  assign Sl_retry = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign user_data_out = data;
  assign unused_ok = ^{OPB_seqAddr, ^C_FAMILY};
  // HOLD waits for select to drop so a long-held request is acked only once
  always_comb begin
    state_n = state == IDLE ? (hit ? ACK : IDLE) : state == ACK ? HOLD : (OPB_select ? HOLD : IDLE);
    data_n = data;
    for (int i = 0; i < 4; i++)
      if (be_q[i]) data_n[31-8*i -: 8] = dbus_q[31-8*i -: 8];
  end
  // Transfer attributes are frozen at the hit so the master may change the bus afterwards
  always_ff @(posedge OPB_Clk) begin
    if (state == IDLE && hit) begin
      sel_q <= OPB_ABus[29];
      rnw_q <= OPB_RNW;
      be_q <= OPB_BE;
      dbus_q <= OPB_DBus;
    end
  end
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state <= IDLE;
      data <= C_DEFAULT;
      wr_count <= '0;
      user_data_strobe <= 1'b0;
    end else begin
      state <= state_n;
      user_data_strobe <= ack && !rnw_q && !sel_q;
      if (ack && !rnw_q) begin
        if (sel_q) wr_count <= '0;
        else begin
          data <= data_n;
          wr_count <= wr_count + 32'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_opb_register_ppc2simulink_sync.sv
// tb_opb_register_ppc2simulink_sync: directed self-checking bench for the PPC-to-Simulink register.
module tb_opb_register_ppc2simulink_sync;
  logic clk = 0, rst = 1;
  logic [0:31] abus = '0, dbus = '0, sl_dbus;
  logic [0:3] be = '0;
  logic rnw = 0, sel = 0, seq = 0;
  logic xack, eack, retry, tout, strobe;
  logic [31:0] ud;
  int n_checks = 0, n_fail = 0;

  opb_register_ppc2simulink_sync dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus),
    .Sl_xferAck(xack), .Sl_errAck(eack), .Sl_retry(retry), .Sl_toutSup(tout),
    .user_data_out(ud), .user_data_strobe(strobe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One OPB transfer; master drops the bus after the ack cycle
  task automatic xfer(input logic [31:0] a, input logic r, input logic [31:0] d, input logic [0:3] b,
                      output logic ack1, output logic ack2, output logic stb, output logic [31:0] rd,
                      output logic [31:0] rd2);
    abus = a; rnw = r; dbus = d; be = b; sel = 1;
    tick();
    ack1 = xack; rd = sl_dbus;
    sel = 0; abus = '0; dbus = '0; be = '0; rnw = 0;
    tick();
    ack2 = xack; stb = strobe; rd2 = sl_dbus;
    tick();
  endtask

  task automatic test_reset();
    logic a1, a2, s;
    logic [31:0] r, r2;
    rst = 1;
    tick(); tick();
    n_checks++; if (ud !== 32'h0) begin n_fail++; $display("FAIL reset_ud got %h exp %h", ud, 32'h0); end
    n_checks++; if (xack !== 1'b0 || sl_dbus !== 32'h0) begin n_fail++; $display("FAIL reset_bus got ack=%b dbus=%h exp 0/0", xack, sl_dbus); end
    n_checks++; if (strobe !== 1'b0 || {eack, retry, tout} !== 3'b000) begin n_fail++; $display("FAIL reset_misc got stb=%b err/rty/to=%b exp 0/000", strobe, {eack, retry, tout}); end
    rst = 0;
    tick();
    xfer(32'h010C0404, 1, 32'h0, 4'b1111, a1, a2, s, r, r2);
    n_checks++; if (a1 !== 1'b1 || r !== 32'h0) begin n_fail++; $display("FAIL reset_count got ack=%b data=%h exp 1/0", a1, r); end
  endtask

  task automatic test_write_read();
    logic a1, a2, s;
    logic [31:0] r, r2;
    xfer(32'h010C0400, 0, 32'hDEADBEEF, 4'b1111, a1, a2, s, r, r2);
    n_checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin n_fail++; $display("FAIL wr_ack got %b%b exp 10", a1, a2); end
    n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL wr_strobe got %b exp 1", s); end
    n_checks++; if (strobe !== 1'b0) begin n_fail++; $display("FAIL wr_strobe_width got %b exp 0", strobe); end
    n_checks++; if (ud !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_data got %h exp DEADBEEF", ud); end
    xfer(32'h010C0400, 1, 32'h0, 4'b1111, a1, a2, s, r, r2);
    n_checks++; if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got %h exp DEADBEEF", r); end
    n_checks++; if (r2 !== 32'h0 || s !== 1'b0) begin n_fail++; $display("FAIL rd_after got dbus=%h stb=%b exp 0/0", r2, s); end
  endtask

  task automatic test_partial_write();
    logic a1, a2, s;
    logic [31:0] r, r2;
    xfer(32'h010C0400, 0, 32'h11223344, 4'b0101, a1, a2, s, r, r2);
    n_checks++; if (ud !== 32'hDE22BE44 || s !== 1'b1) begin n_fail++; $display("FAIL be_data got %h stb=%b exp DE22BE44/1", ud, s); end
    xfer(32'h010C0404, 1, 32'h0, 4'b1111, a1, a2, s, r, r2);
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL count2 got %h exp 2", r); end
    xfer(32'h010C0400, 0, 32'hFFFFFFFF, 4'b0000, a1, a2, s, r, r2);
    n_checks++; if (ud !== 32'hDE22BE44 || s !== 1'b1) begin n_fail++; $display("FAIL be_none got %h stb=%b exp DE22BE44/1", ud, s); end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    abus = 32'h010C0400; rnw = 1; sel = 1;
    for (int i = 0; i < 5; i++) begin tick(); acks += int'(xack); end
    sel = 0;
    tick(); tick();
    n_checks++; if (acks != 1) begin n_fail++; $display("FAIL hold_acks got %0d exp 1", acks); end
    acks = 0;
    abus = 32'h010C0500; rnw = 0; dbus = 32'h0BADF00D; be = 4'b1111; sel = 1;
    for (int i = 0; i < 5; i++) begin tick(); acks += int'(xack | strobe); end
    sel = 0;
    tick(); tick();
    n_checks++; if (acks != 0 || ud !== 32'hDE22BE44) begin n_fail++; $display("FAIL miss got acks=%0d ud=%h exp 0/DE22BE44", acks, ud); end
  endtask

  task automatic test_counter();
    logic a1, a2, s;
    logic [31:0] r, r2;
    force dut.wr_count = 32'hFFFFFFFF;
    #1;
    release dut.wr_count;
    xfer(32'h010C0400, 0, 32'hAAAA5555, 4'b1111, a1, a2, s, r, r2);
    xfer(32'h010C0404, 1, 32'h0, 4'b1111, a1, a2, s, r, r2);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL count_wrap got %h exp 0", r); end
    xfer(32'h010C0400, 0, 32'h0F0F0F0F, 4'b1111, a1, a2, s, r, r2);
    xfer(32'h010C0404, 1, 32'h0, 4'b1111, a1, a2, s, r, r2);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL count_inc got %h exp 1", r); end
    xfer(32'h010C0404, 0, 32'h12345678, 4'b1111, a1, a2, s, r, r2);
    n_checks++; if (a1 !== 1'b1 || s !== 1'b0 || ud !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL clr_wr got ack=%b stb=%b ud=%h exp 1/0/0F0F0F0F", a1, s, ud); end
    xfer(32'h010C0404, 1, 32'h0, 4'b1111, a1, a2, s, r, r2);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL count_clr got %h exp 0", r); end
  endtask

  task automatic test_reset_mid_ack();
    abus = 32'h010C0400; rnw = 0; dbus = 32'h12345678; be = 4'b1111; sel = 1;
    tick();
    n_checks++; if (xack !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ack got %b exp 1", xack); end
    rst = 1; sel = 0;
    tick();
    n_checks++; if (strobe !== 1'b0 || ud !== 32'h0 || xack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got stb=%b ud=%h ack=%b exp 0/0/0", strobe, ud, xack); end
    rst = 0;
    tick();
    n_checks++; if (strobe !== 1'b0 || ud !== 32'h0 || sl_dbus !== 32'h0) begin n_fail++; $display("FAIL rst_after got stb=%b ud=%h dbus=%h exp 0/0/0", strobe, ud, sl_dbus); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_counter();
    test_reset_mid_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
